// File: rtl/sdram_aref_ctrl.sv
// SDRAM auto-refresh controller: interval timer, request/grant, PRECHARGE ALL + N x AUTO REFRESH.
// Optional sticky missed-interval flag when AREF_MISS_FLAG_EN is defined.
module sdram_aref_ctrl #(
  parameter int CLK_FREQ_MHZ  = 50,
  parameter int REF_PERIOD_US = 15,
  parameter int T_RP          = 2,
  parameter int T_RFC         = 7,
  parameter int REF_NUM       = 2
) (
  input  logic        Sys_clk,
  input  logic        Rst_n,
  input  logic        Init_done,
  input  logic        Aref_en,
  output logic        Aref_req,
  output logic        Aref_end,
  output logic [3:0]  Aref_cmd,
  output logic [11:0] Aref_addr,
  output logic [1:0]  Aref_bank
`ifdef AREF_MISS_FLAG_EN
  ,
  output logic        Aref_miss
`endif
);

  localparam int CNT_TOP = CLK_FREQ_MHZ * REF_PERIOD_US;
  localparam int CW = (CNT_TOP > 1) ? $clog2(CNT_TOP) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CNT_TOP - 1);
  localparam int WMAX = (T_RP > T_RFC) ? T_RP : T_RFC;
  localparam int WW = (WMAX > 1) ? $clog2(WMAX + 1) : 1;
  localparam logic [WW-1:0] TRP_LAST = WW'(T_RP - 1);
  localparam logic [WW-1:0] TRFC_LAST = WW'(T_RFC - 1);
  localparam int RW = $clog2(REF_NUM + 1);
  localparam logic [RW-1:0] RNUM = RW'(REF_NUM);

  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_PCH = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;

  typedef enum logic [2:0] {
    S_IDLE, S_PCH, S_TRP, S_REF, S_TRF, S_END
  } state_t;

  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic req_q, req_d;
  logic end_q, end_d;
  logic [3:0] cmd_q, cmd_d;
  logic [11:0] addr_q, addr_d;
  logic wrap, accept;

  assign wrap   = Init_done && (cnt_q == CNT_MAX);
  assign accept = (state_q == S_IDLE) && req_q && Aref_en;

  // Interval timer free-runs through refresh so the period ignores grant latency
  always_comb begin
    cnt_d = '0;
    if (Init_done && !wrap) cnt_d = cnt_q + CW'(1);
  end

  // A new wrap outranks the clear from a same-cycle grant
  always_comb begin
    req_d = req_q;
    if (!Init_done) req_d = 1'b0;
    else if (wrap) req_d = 1'b1;
    else if (accept) req_d = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    rcnt_d  = rcnt_q;
    unique case (state_q)
      S_IDLE: begin
        rcnt_d = '0;
        if (accept) state_d = S_PCH;
      end
      S_PCH: begin
        state_d = S_TRP;
        wcnt_d  = '0;
      end
      S_TRP: begin
        if (wcnt_q == TRP_LAST) state_d = S_REF;
        else wcnt_d = wcnt_q + WW'(1);
      end
      S_REF: begin
        state_d = S_TRF;
        wcnt_d  = '0;
        rcnt_d  = rcnt_q + RW'(1);
      end
      S_TRF: begin
        if (wcnt_q == TRFC_LAST)
          state_d = (rcnt_q < RNUM) ? S_REF : S_END;
        else
          wcnt_d = wcnt_q + WW'(1);
      end
      S_END: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it
  always_comb begin
    cmd_d  = CMD_NOP;
    addr_d = 12'hFFF;
    end_d  = 1'b0;
    unique case (1'b1)
      (state_d == S_PCH): begin
        cmd_d  = CMD_PCH;
        addr_d = 12'h400;
      end
      (state_d == S_REF): cmd_d = CMD_REF;
      (state_d == S_END): end_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge Sys_clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wcnt_q  <= '0;
      rcnt_q  <= '0;
      req_q   <= 1'b0;
      end_q   <= 1'b0;
      cmd_q   <= CMD_NOP;
      addr_q  <= 12'hFFF;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wcnt_q  <= wcnt_d;
      rcnt_q  <= rcnt_d;
      req_q   <= req_d;
      end_q   <= end_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
    end
  end

`ifdef AREF_MISS_FLAG_EN
  logic miss_q;

  always_ff @(posedge Sys_clk or negedge Rst_n) begin
    if (!Rst_n) miss_q <= 1'b0;
    else if (wrap && req_q) miss_q <= 1'b1;
  end

  assign Aref_miss = miss_q;
`endif

  assign Aref_req  = req_q;
  assign Aref_end  = end_q;
  assign Aref_cmd  = cmd_q;
  assign Aref_addr = addr_q;
  assign Aref_bank = 2'b11;

endmodule

// File: tb/tb_sdram_aref_ctrl.sv
// Randomized bench for sdram_aref_ctrl against a cycle-offset reference model.
// Miss-flag checks compile in when AREF_MISS_FLAG_EN is defined.
module tb_sdram_aref_ctrl;

  localparam int CLK = 50;
  localparam int PER = 15;
  localparam int TRP = 2;
  localparam int TRFC = 7;
  localparam int RNUM = 2;
  localparam int IVL = CLK * PER;
  localparam int LEN = 1 + TRP + RNUM * (1 + TRFC);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic init = 1'b0;
  logic en = 1'b0;
  logic req, aend;
  logic [3:0] cmd;
  logic [11:0] addr;
  logic [1:0] bank;
`ifdef AREF_MISS_FLAG_EN
  logic miss;
`endif

  always #5 clk = ~clk;

  sdram_aref_ctrl #(
    .CLK_FREQ_MHZ(CLK), .REF_PERIOD_US(PER),
    .T_RP(TRP), .T_RFC(TRFC), .REF_NUM(RNUM)
  ) dut (
    .Sys_clk(clk), .Rst_n(rst_n), .Init_done(init),
    .Aref_en(en), .Aref_req(req), .Aref_end(aend),
    .Aref_cmd(cmd), .Aref_addr(addr), .Aref_bank(bank)
`ifdef AREF_MISS_FLAG_EN
    , .Aref_miss(miss)
`endif
  );

  int n_chk = 0;
  int n_pass = 0;

  int m_ticks = 0;
  int m_off = 0;
  bit m_req = 0;
  bit m_miss = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int exp_cmd(input int off);
    if (off == 1) return 4'b0010;
    if (off >= 2 + TRP && off <= LEN &&
        ((off - 2 - TRP) % (1 + TRFC)) == 0) return 4'b0001;
    return 4'b0111;
  endfunction

  task automatic model_reset();
    m_ticks = 0;
    m_off = 0;
    m_req = 0;
    m_miss = 0;
  endtask

  task automatic model_edge();
    bit acc, wrap;
    if (!rst_n) begin
      model_reset();
      return;
    end
    acc = (m_off == 0) && m_req && en;
    if (init) m_ticks++;
    else m_ticks = 0;
    wrap = init && m_ticks > 0 && (m_ticks % IVL) == 0;
    if (wrap && m_req) m_miss = 1;
    if (acc) m_off = 1;
    else if (m_off == 0 || m_off == LEN + 1) m_off = 0;
    else m_off++;
    if (!init) m_req = 0;
    else if (wrap) m_req = 1;
    else if (acc) m_req = 0;
  endtask

  task automatic check_outs();
    chk("cmd", cmd, exp_cmd(m_off));
    chk("addr", addr, (m_off == 1) ? 12'h400 : 12'hFFF);
    chk("bank", bank, 2'b11);
    chk("end", aend, (m_off == LEN + 1) ? 1 : 0);
    chk("req", req, m_req);
`ifdef AREF_MISS_FLAG_EN
    chk("miss", miss, m_miss);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outs();
  endtask

  initial begin
    int n, k;
    bit found;

    #12;
    check_outs();
    @(negedge clk);
    rst_n = 1'b1;
    init = 1'b1;

    n = 0;
    while (!req && n < IVL + 50) begin
      step();
      n++;
    end
    chk("first_req_lat", n, IVL);

    en = 1'b1;
    k = 0;
    for (int i = 1; i <= 25; i++) begin
      step();
      if (aend) k = i;
    end
    en = 1'b0;
    chk("end_cycle", k, LEN + 1);

    n = 25;
    while (!req && n < 2 * IVL) begin
      step();
      n++;
    end
    chk("req_interval", n, IVL);

    for (int i = 0; i < 4000; i++) begin
      en = ($urandom % 4) == 0;
      if (init && ($urandom % 1200) == 0) init = 1'b0;
      else if (!init && ($urandom % 20) == 0) init = 1'b1;
      step();
    end

    init = 1'b1;
    en = 1'b1;
    found = 0;
    for (int i = 0; i < 2 * IVL + 100 && !found; i++) begin
      step();
      if (m_off == 2 + TRP + 2) found = 1;
    end
    en = 1'b0;
    chk("reach_trf", found, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_cmd", cmd, 4'b0111);
    chk("rst_addr", addr, 12'hFFF);
    chk("rst_bank", bank, 2'b11);
    chk("rst_req", req, 0);
    chk("rst_end", aend, 0);
    model_reset();
    for (int i = 0; i < 3; i++) step();
    rst_n = 1'b1;
    n = 0;
    while (!req && n < IVL + 50) begin
      step();
      n++;
    end
    chk("resume_lat", n, IVL);
    en = 1'b1;
    for (int i = 0; i < 30; i++) step();
    en = 1'b0;

    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 1600; i++) step();
`ifdef AREF_MISS_FLAG_EN
    chk("miss_set", miss, 1);
`endif
    en = 1'b1;
    for (int i = 0; i < 30; i++) step();
    en = 1'b0;
`ifdef AREF_MISS_FLAG_EN
    chk("miss_sticky", miss, 1);
`endif
    for (int i = 0; i < 20; i++) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
